// File: rtl/axis_row_pkg.sv
// -----------------------------------------------------------------------------
// axis_row_pkg
// Shared types and constants for the AXI-Stream row consumer.
//   row_state_t  : framing FSM encoding (IDLE = no beats in row, ACTIVE = mid-row)
//   ROW_COUNT_W  : width of the completed-row statistics counter
// -----------------------------------------------------------------------------
package axis_row_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } row_state_t;

    localparam int ROW_COUNT_W = 32;

endpackage

// File: rtl/axis_row_consumer_if.sv
// -----------------------------------------------------------------------------
// axis_row_consumer_if
// AXI-Stream bundle carried into the row consumer.
//   master : drives AXIS_TDATA / AXIS_TVALID / AXIS_TLAST, receives AXIS_TREADY
//   slave  : receives data/valid/last, drives AXIS_TREADY
// -----------------------------------------------------------------------------
interface axis_row_consumer_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] AXIS_TDATA;
    logic                  AXIS_TVALID;
    logic                  AXIS_TLAST;
    logic                  AXIS_TREADY;

    modport master (
        output AXIS_TDATA,
        output AXIS_TVALID,
        output AXIS_TLAST,
        input  AXIS_TREADY
    );

    modport slave (
        input  AXIS_TDATA,
        input  AXIS_TVALID,
        input  AXIS_TLAST,
        output AXIS_TREADY
    );
endinterface

// File: rtl/axis_idle_timer.sv
// -----------------------------------------------------------------------------
// axis_idle_timer
// Reloadable down-counter used to detect a stalled stream.
//   clk, resetn : clock, synchronous active-low reset (count cleared)
//   i_load      : reload the counter with TIMEOUT (has priority)
//   i_dec_en    : count down by one this cycle
//   o_expired   : high in the cycle whose decrement takes the count from 1
//                 to 0, i.e. on the TIMEOUT-th consecutive decrement
// -----------------------------------------------------------------------------
module axis_idle_timer #(
    parameter int TIMEOUT_W = 32,
    parameter int TIMEOUT   = 400000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_load,
    input  logic i_dec_en,
    output logic o_expired
);

    logic [TIMEOUT_W-1:0] r_count;

    // Combinational so the owner can act on the same edge the count hits 0;
    // a load on that edge overrides the expiry.
    assign o_expired = i_dec_en && !i_load && (r_count == TIMEOUT_W'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= TIMEOUT_W'(TIMEOUT);
        end else if (i_dec_en && (r_count != '0)) begin
            r_count <= r_count - TIMEOUT_W'(1);
        end
    end

endmodule

// File: rtl/axis_row_consumer.sv
// -----------------------------------------------------------------------------
// axis_row_consumer
// Always-available AXI-Stream sink that frames beats into rows of a
// programmable length and reports row boundaries, timed-out partial rows and
// TLAST framing errors. Data is discarded.
//   clk, resetn    : clock, synchronous active-low reset
//   enable         : registered into AXIS_TREADY (one cycle latency)
//   beats_per_row  : row length, 0 behaves as 1; sampled on every beat
//   s_axis         : stream input (slave modport)
//   row_complete   : strobe, final beat of a row accepted
//   partial_row    : strobe, ACTIVE row idle for IDLE_TIMEOUT cycles
//   tlast_error    : strobe, TLAST disagrees with the row boundary
//   beat_index     : beats accepted in the current row
//   row_count      : completed rows since reset (wraps)
// -----------------------------------------------------------------------------
module axis_row_consumer
    import axis_row_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int BEATS_W      = 8,
    parameter int IDLE_TIMEOUT = 400000000,
    parameter int TIMEOUT_W    = 32,
    parameter int CHECK_TLAST  = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [BEATS_W-1:0]     beats_per_row,
    axis_row_consumer_if.slave     s_axis,
    output logic                   row_complete,
    output logic                   partial_row,
    output logic                   tlast_error,
    output logic [BEATS_W-1:0]     beat_index,
    output logic [ROW_COUNT_W-1:0] row_count
);

    row_state_t             r_state;
    logic                   r_tready;
    logic                   r_row_complete;
    logic                   r_partial_row;
    logic                   r_tlast_error;
    logic [BEATS_W-1:0]     r_beat_index;
    logic [ROW_COUNT_W-1:0] r_row_count;

    logic [DATA_WIDTH-1:0]  w_unused_tdata;
    logic                   w_beat;
    logic [BEATS_W-1:0]     w_target;
    logic [BEATS_W:0]       w_next_idx;
    logic                   w_final;
    logic                   w_early_last;
    logic                   w_timer_load;
    logic                   w_timer_dec;
    logic                   w_expired;

    assign w_unused_tdata = s_axis.AXIS_TDATA;

    assign w_beat     = s_axis.AXIS_TVALID && r_tready;
    assign w_target   = (beats_per_row == '0) ? BEATS_W'(1) : beats_per_row;
    // One extra bit so index+1 cannot wrap when the index is at its maximum.
    assign w_next_idx = {1'b0, r_beat_index} + (BEATS_W+1)'(1);
    // ">=" rather than "==" so shrinking the row length below the current
    // index terminates the row on the very next beat.
    assign w_final    = (w_next_idx >= {1'b0, w_target});

    // TLAST before the boundary: drop the row and resync to the sender.
    assign w_early_last = (CHECK_TLAST != 0) && w_beat && !w_final && s_axis.AXIS_TLAST;

    assign w_timer_load = w_beat && !w_final && !w_early_last;
    // Keeps running while disabled so a stalled row is still reported.
    assign w_timer_dec  = (r_state == ST_ACTIVE) && !w_beat;

    axis_idle_timer #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk       (clk),
        .resetn    (resetn),
        .i_load    (w_timer_load),
        .i_dec_en  (w_timer_dec),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_tready       <= 1'b0;
            r_row_complete <= 1'b0;
            r_partial_row  <= 1'b0;
            r_tlast_error  <= 1'b0;
            r_beat_index   <= '0;
            r_row_count    <= '0;
        end else begin
            r_tready       <= enable;
            r_row_complete <= 1'b0;
            r_partial_row  <= 1'b0;
            r_tlast_error  <= 1'b0;
            if (w_beat) begin
                if (w_final) begin
                    r_row_complete <= 1'b1;
                    r_tlast_error  <= (CHECK_TLAST != 0) && !s_axis.AXIS_TLAST;
                    r_row_count    <= r_row_count + ROW_COUNT_W'(1);
                    r_beat_index   <= '0;
                    r_state        <= ST_IDLE;
                end else if (w_early_last) begin
                    r_tlast_error  <= 1'b1;
                    r_beat_index   <= '0;
                    r_state        <= ST_IDLE;
                end else begin
                    r_beat_index   <= w_next_idx[BEATS_W-1:0];
                    r_state        <= ST_ACTIVE;
                end
            end else if (w_expired) begin
                r_partial_row <= 1'b1;
                r_beat_index  <= '0;
                r_state       <= ST_IDLE;
            end
        end
    end

    assign s_axis.AXIS_TREADY = r_tready;
    assign row_complete       = r_row_complete;
    assign partial_row        = r_partial_row;
    assign tlast_error        = r_tlast_error;
    assign beat_index         = r_beat_index;
    assign row_count          = r_row_count;

endmodule
